mips_dmem_arbiter: RTL and testbench

MIPS_DMEM_ARBITER -- requirements
Module: mips_dmem_arbiter

---
 rtl/mips_dmem_arbiter.sv | 108 ++++++++++
 tb/tb_mips_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port data memory.
// CPU has priority; a DMA request denied STARVE_LIMIT cycles in a row is forced through.
module mips_dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        dma_wait_reg, dma_wait_next;
  logic              cpu_rd_reg, dma_rd_reg;
  logic [DATA_W-1:0] rdata_hold_reg;
  logic [15:0]       conflict_cnt_reg, conflict_cnt_next;
  logic              starved;

  assign starved = (dma_wait_reg == LIMIT);

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (cpu_req && dma_req) begin
      cpu_gnt = ~starved;
      dma_gnt = starved;
    end else begin
      cpu_gnt = cpu_req;
      dma_gnt = dma_req;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory port follows whichever side won; idle bus is driven to zero.
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    dma_wait_next = 4'd0;
    if (dma_req && !dma_gnt)
      dma_wait_next = starved ? dma_wait_reg : dma_wait_reg + 4'd1;
  end

  always_comb begin
    conflict_cnt_next = conflict_cnt_reg;
    if (cpu_req && dma_req && (conflict_cnt_reg != 16'hFFFF))
      conflict_cnt_next = conflict_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      dma_wait_reg     <= 4'd0;
      conflict_cnt_reg <= 16'd0;
      cpu_rd_reg       <= 1'b0;
      dma_rd_reg       <= 1'b0;
      rdata_hold_reg   <= '0;
    end else begin
      dma_wait_reg     <= dma_wait_next;
      conflict_cnt_reg <= conflict_cnt_next;
      cpu_rd_reg       <= cpu_gnt & ~cpu_we;
      dma_rd_reg       <= dma_gnt & ~dma_we;
      if (cpu_rd_reg || dma_rd_reg)
        rdata_hold_reg <= mem_rdata;
    end
  end

  // Read data passes straight through in the rvalid cycle, then is held.
  assign rdata        = (cpu_rd_reg | dma_rd_reg) ? mem_rdata : rdata_hold_reg;
  assign cpu_rvalid   = cpu_rd_reg;
  assign dma_rvalid   = dma_rd_reg;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed and randomized checks of mips_dmem_arbiter against a bench-side
// synchronous memory and a small arbitration reference model.
module tb_mips_dmem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [9:0]  cpu_addr, dma_addr;
  logic [63:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [63:0] rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] conflict_cnt;

  logic [63:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk1 = ~clk1;

  mips_dmem_arbiter #(.ADDR_W(10), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Synchronous single-port memory with registered read.
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [63:0] cd,
                       input logic dr, input logic dw, input logic [9:0] da, input logic [63:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic idle;
    drive(0, 0, 10'd0, 64'd0, 0, 0, 10'd0, 64'd0);
  endtask

  initial begin
    logic [3:0]  wait_m;
    logic [15:0] cc_m;
    logic        exp_cg, exp_dg, exp_crv, exp_drv, cpu_hold, dma_hold;
    logic [63:0] exp_rd;

    for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
    mem[120] = 64'd85;
    mem_rdata = 64'd0;
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_conflict", conflict_cnt, 0);
    check("rst_mem_en", mem_en, 0);
    @(negedge clk1);
    rst_n = 1'b1;

    // CPU-only load of address 120
    tick(); drive(1, 0, 10'd120, 64'd0, 0, 0, 10'd0, 64'd0);
    @(negedge clk1);
    $display("txn cpu load addr=120");
    check("ld_cpu_gnt", cpu_gnt, 1);
    check("ld_mem_addr", mem_addr, 120);
    check("ld_mem_we", mem_we, 0);
    check("ld_stall", cpu_stall, 0);
    tick(); idle();
    @(negedge clk1);
    check("ld_cpu_rvalid", cpu_rvalid, 1);
    check("ld_rdata", rdata, 85);
    check("ld_dma_rvalid", dma_rvalid, 0);
    tick();
    @(negedge clk1);
    check("ld_rvalid_once", cpu_rvalid, 0);
    check("ld_rdata_hold", rdata, 85);

    // CPU store 130 to 121 then load it back
    tick(); drive(1, 1, 10'd121, 64'd130, 0, 0, 10'd0, 64'd0);
    @(negedge clk1);
    $display("txn cpu store addr=121 data=130");
    check("st_mem_we", mem_we, 1);
    check("st_mem_wdata", mem_wdata, 130);
    check("st_mem_addr", mem_addr, 121);
    tick(); drive(1, 0, 10'd121, 64'd0, 0, 0, 10'd0, 64'd0);
    @(negedge clk1);
    $display("txn cpu load addr=121");
    check("st_no_rvalid", cpu_rvalid, 0);
    check("st_ld_gnt", cpu_gnt, 1);
    tick(); idle();
    @(negedge clk1);
    check("st_ld_rvalid", cpu_rvalid, 1);
    check("st_ld_rdata", rdata, 130);

    // Back-to-back: CPU read 120 then DMA read 121
    tick(); drive(1, 0, 10'd120, 64'd0, 0, 0, 10'd0, 64'd0);
    @(negedge clk1);
    check("b2b_cpu_gnt", cpu_gnt, 1);
    tick(); drive(0, 0, 10'd0, 64'd0, 1, 0, 10'd121, 64'd0);
    @(negedge clk1);
    $display("txn b2b cpu rd 120 / dma rd 121");
    check("b2b_dma_gnt", dma_gnt, 1);
    check("b2b_cpu_rvalid", cpu_rvalid, 1);
    check("b2b_rdata0", rdata, 85);
    tick(); idle();
    @(negedge clk1);
    check("b2b_dma_rvalid", dma_rvalid, 1);
    check("b2b_cpu_rvalid_off", cpu_rvalid, 0);
    check("b2b_rdata1", rdata, 130);

    // Starvation: both requesting writes for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick(); drive(1, 1, 10'd200, 64'd7, 1, 1, 10'd201, 64'd9);
      @(negedge clk1);
      $display("txn starve cycle=%0d cpu_gnt=%0b dma_gnt=%0b", i, cpu_gnt, dma_gnt);
      check("stv_cpu_gnt", cpu_gnt, (i % 5) != 4);
      check("stv_dma_gnt", dma_gnt, (i % 5) == 4);
      check("stv_stall", cpu_stall, (i % 5) == 4);
      check("stv_conflict", conflict_cnt, i);
    end
    tick(); idle();
    @(negedge clk1);
    check("stv_conflict10", conflict_cnt, 10);
    check("stv_no_rvalid", cpu_rvalid | dma_rvalid, 0);

    // DMA-only write burst to 0..7
    for (int i = 0; i < 8; i++) begin
      tick(); drive(0, 0, 10'd0, 64'd0, 1, 1, 10'(i), 64'h1000 + 64'(i));
      @(negedge clk1);
      $display("txn dma write addr=%0d", i);
      check("brst_dma_gnt", dma_gnt, 1);
      check("brst_mem_we", mem_we, 1);
      check("brst_mem_addr", mem_addr, i);
      check("brst_no_rvalid", cpu_rvalid | dma_rvalid, 0);
    end
    tick(); idle();
    @(negedge clk1);
    for (int i = 0; i < 8; i++) check("brst_mem", mem[i], 64'h1000 + 64'(i));
    // dma_wait must still be 0: CPU wins four contested cycles before DMA
    for (int i = 0; i < 5; i++) begin
      tick(); drive(1, 1, 10'd200, 64'd1, 1, 1, 10'd201, 64'd2);
      @(negedge clk1);
      check("brst_wait_dma_gnt", dma_gnt, i == 4);
    end
    tick(); idle();
    @(negedge clk1);
    check("brst_conflict", conflict_cnt, 15);

    // Reset during an outstanding DMA read
    tick(); drive(0, 0, 10'd0, 64'd0, 1, 0, 10'd3, 64'd0);
    @(negedge clk1);
    $display("txn dma read addr=3 with reset");
    check("rr_dma_gnt", dma_gnt, 1);
    #3;
    rst_n = 1'b0;
    idle();
    #1;
    check("rr_conflict_async", conflict_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_rvalid_in_rst", dma_rvalid, 0);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_rvalid_after", dma_rvalid, 0);
      check("rr_rdata", rdata, 0);
      check("rr_conflict", conflict_cnt, 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(); drive(1, 1, 10'd200, 64'd1, 1, 1, 10'd201, 64'd2);
      @(negedge clk1);
      check("rr_wait_dma_gnt", dma_gnt, i == 4);
    end
    wait_m = 4'd0;
    cc_m = 16'd5;

    // Random traffic against the reference model
    exp_crv = 0; exp_drv = 0; exp_rd = 0;
    cpu_hold = 0; dma_hold = 0;
    for (int n = 0; n < 10000; n++) begin
      tick();
      if (!cpu_hold) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 10'($urandom_range(0, 15)); cpu_wdata = {$urandom, $urandom};
      end
      if (!dma_hold) begin
        dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
        dma_addr = 10'($urandom_range(0, 15)); dma_wdata = {$urandom, $urandom};
      end
      exp_cg = cpu_req & (~dma_req | (wait_m != 4'd4));
      exp_dg = dma_req & (~cpu_req | (wait_m == 4'd4));
      @(negedge clk1);
      check("rnd_excl", cpu_gnt & dma_gnt, 0);
      check("rnd_cpu_gnt", cpu_gnt, exp_cg);
      check("rnd_dma_gnt", dma_gnt, exp_dg);
      check("rnd_cpu_rvalid", cpu_rvalid, exp_crv);
      check("rnd_dma_rvalid", dma_rvalid, exp_drv);
      if (exp_crv | exp_drv) check("rnd_rdata", rdata, exp_rd);
      if (exp_cg) begin
        check("rnd_mem_addr_c", mem_addr, cpu_addr);
        check("rnd_mem_we_c", mem_we, cpu_we);
        if (cpu_we) check("rnd_mem_wdata_c", mem_wdata, cpu_wdata);
      end else if (exp_dg) begin
        check("rnd_mem_addr_d", mem_addr, dma_addr);
        check("rnd_mem_we_d", mem_we, dma_we);
        if (dma_we) check("rnd_mem_wdata_d", mem_wdata, dma_wdata);
      end else begin
        check("rnd_mem_en", mem_en, 0);
      end
      exp_crv = exp_cg & ~cpu_we;
      exp_drv = exp_dg & ~dma_we;
      if (exp_crv) exp_rd = mem[cpu_addr];
      else if (exp_drv) exp_rd = mem[dma_addr];
      if (dma_req & ~exp_dg) wait_m = (wait_m == 4'd4) ? wait_m : wait_m + 4'd1;
      else wait_m = 4'd0;
      if (cpu_req & dma_req) cc_m = cc_m + 16'd1;
      cpu_hold = cpu_req & ~exp_cg;
      dma_hold = dma_req & ~exp_dg;
    end
    $display("txn random 10000 cycles done");
    tick(); idle();
    @(negedge clk1);
    check("rnd_last_cpu_rvalid", cpu_rvalid, exp_crv);
    check("rnd_last_dma_rvalid", dma_rvalid, exp_drv);
    check("rnd_conflict", conflict_cnt, cc_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
